regs: RTL and testbench

Integer register file for the five-stage core: 32 × 32-bit architectural registers, x0 hardwired to zero. Receives the execute-stage writeback (rd address, data, write enable) and serves two combinational read ports to the decode stage. A write-to-read bypass on the decode ports returns a same-cycle write without a pipeline bubble. A secondary debug port gives registered read/write access for the JTAG/debug module, with execute writes taking priority.

---
 rtl/regs_if.sv | 41 ++++
 rtl/regs.sv | 78 +++++++
 tb/tb_regs.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/regs_if.sv
// -----------------------------------------------------------------------------
// regs_if : bundle between the core / debug module (master) and the integer
// register file (slave).
//   rd_addr_i / rd_data_i / reg_wen_i : execute-stage writeback
//   rs1_addr_i, rs2_addr_i            : decode read addresses
//   rs1_data_o, rs2_data_o            : decode read data (combinational)
//   dbg_addr_i / dbg_data_i           : debug access address / write data
//   dbg_wen_i, dbg_ren_i              : debug write / read requests
//   dbg_ready_o                       : debug write accepted this cycle
//   dbg_data_o, dbg_rvalid_o          : registered debug read data + valid pulse
// -----------------------------------------------------------------------------
interface regs_if #(
   parameter int REG_W = 32
);
   logic [4:0]       rd_addr_i;
   logic [REG_W-1:0] rd_data_i;
   logic             reg_wen_i;
   logic [4:0]       rs1_addr_i;
   logic [4:0]       rs2_addr_i;
   logic [REG_W-1:0] rs1_data_o;
   logic [REG_W-1:0] rs2_data_o;
   logic [4:0]       dbg_addr_i;
   logic [REG_W-1:0] dbg_data_i;
   logic             dbg_wen_i;
   logic             dbg_ren_i;
   logic             dbg_ready_o;
   logic [REG_W-1:0] dbg_data_o;
   logic             dbg_rvalid_o;

   modport master (
      output rd_addr_i, rd_data_i, reg_wen_i, rs1_addr_i, rs2_addr_i,
             dbg_addr_i, dbg_data_i, dbg_wen_i, dbg_ren_i,
      input  rs1_data_o, rs2_data_o, dbg_ready_o, dbg_data_o, dbg_rvalid_o
   );

   modport slave (
      input  rd_addr_i, rd_data_i, reg_wen_i, rs1_addr_i, rs2_addr_i,
             dbg_addr_i, dbg_data_i, dbg_wen_i, dbg_ren_i,
      output rs1_data_o, rs2_data_o, dbg_ready_o, dbg_data_o, dbg_rvalid_o
   );
endinterface

// File: rtl/regs.sv
// -----------------------------------------------------------------------------
// regs : integer register file, REG_NUM x REG_W, x0 hardwired to zero.
//   clk  : core clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : regs_if.slave -- execute writeback, two combinational decode read
//          ports with writeback bypass, and a debug port (arbitrated write,
//          registered read with one-cycle valid pulse).
// -----------------------------------------------------------------------------
module regs #(
   parameter int REG_NUM = 32,
   parameter int REG_W   = 32
) (
   input  logic  clk,
   input  logic  rst,
   regs_if.slave bus
);

   localparam int RP = 3;  // read ports: rs1, rs2, debug

   logic [REG_W-1:0]      mem [REG_NUM];
   logic                  ex_we;
   logic                  dbg_we;
   logic [RP-1:0][4:0]    rp_addr;
   logic [RP-1:0][REG_W-1:0] rp_data;

   // Address 0 and addresses beyond REG_NUM hold no storage.
   function automatic logic addr_ok(input logic [4:0] a);
      return (a != 5'd0) && (int'(a) < REG_NUM);
   endfunction

   assign ex_we           = bus.reg_wen_i & addr_ok(bus.rd_addr_i);
   // Execute writeback always wins the single write port.
   assign bus.dbg_ready_o = bus.dbg_wen_i & ~bus.reg_wen_i;
   assign dbg_we          = bus.dbg_ready_o & addr_ok(bus.dbg_addr_i);

   assign rp_addr = {bus.dbg_addr_i, bus.rs2_addr_i, bus.rs1_addr_i};

   // All three read ports share one rule: only the execute write is
   // bypassed; a debug write becomes visible after its edge.
   always_comb begin
      rp_data = '0;
      for (int p = 0; p < RP; p++) begin
         if (!addr_ok(rp_addr[p]))
            rp_data[p] = '0;
         else if (ex_we && (bus.rd_addr_i == rp_addr[p]))
            rp_data[p] = bus.rd_data_i;
         else
            rp_data[p] = mem[rp_addr[p]];
      end
   end

   assign bus.rs1_data_o = rp_data[0];
   assign bus.rs2_data_o = rp_data[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < REG_NUM; i++) mem[i] <= '0;
      end else begin
         if (ex_we)
            mem[bus.rd_addr_i] <= bus.rd_data_i;
         else if (dbg_we)
            mem[bus.dbg_addr_i] <= bus.dbg_data_i;
      end
   end

   // Debug read samples the pre-edge value, so a colliding debug write
   // to the same address returns the old contents.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.dbg_data_o   <= '0;
         bus.dbg_rvalid_o <= 1'b0;
      end else begin
         bus.dbg_rvalid_o <= bus.dbg_ren_i;
         if (bus.dbg_ren_i) bus.dbg_data_o <= rp_data[2];
      end
   end

endmodule

// File: tb/tb_regs.sv
module tb_regs;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   regs_if #(.REG_W(32)) bus();

   regs #(.REG_NUM(32), .REG_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;

   // reference model state
   logic [31:0] m_rf [32];
   logic [31:0] m_dbg;
   logic        m_rv;

   // combinational outputs sampled by the last tick()
   logic [31:0] s_rs1, s_rs2;
   logic        s_rdy;

   typedef struct {
      logic        wen;  logic [4:0] rd;  logic [31:0] rdd;
      logic [4:0]  r1;   logic [4:0] r2;
      logic        dwen; logic       dren; logic [4:0] da; logic [31:0] dd;
      logic [31:0] e1;   logic [31:0] e2;
      logic        erdy; logic       erv;  logic [31:0] edbg;
   } vec_t;

   vec_t tv [16];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_read(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (bus.reg_wen_i && bus.rd_addr_i == a) return bus.rd_data_i;
      return m_rf[a];
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
      m_dbg = 32'd0;
      m_rv  = 1'b0;
   endtask

   task automatic drive(input logic wen, input logic [4:0] rd, input logic [31:0] rdd,
                        input logic [4:0] r1, input logic [4:0] r2,
                        input logic dwen, input logic dren, input logic [4:0] da,
                        input logic [31:0] dd);
      bus.reg_wen_i  = wen;  bus.rd_addr_i = rd; bus.rd_data_i = rdd;
      bus.rs1_addr_i = r1;   bus.rs2_addr_i = r2;
      bus.dbg_wen_i  = dwen; bus.dbg_ren_i = dren;
      bus.dbg_addr_i = da;   bus.dbg_data_i = dd;
   endtask

   // Called with inputs stable, shortly after a rising edge. Checks the
   // combinational outputs mid-cycle, advances the model across the next
   // edge, then checks the registered debug outputs.
   task automatic tick();
      logic [31:0] snap;
      logic        rdy;
      @(negedge clk);
      s_rs1 = bus.rs1_data_o;
      s_rs2 = bus.rs2_data_o;
      s_rdy = bus.dbg_ready_o;
      rdy   = bus.dbg_wen_i && !bus.reg_wen_i;
      chk("rs1_data", s_rs1, m_read(bus.rs1_addr_i));
      chk("rs2_data", s_rs2, m_read(bus.rs2_addr_i));
      chk("dbg_ready", {31'd0, s_rdy}, {31'd0, rdy});
      @(posedge clk);
      snap = m_read(bus.dbg_addr_i);
      if (bus.reg_wen_i && bus.rd_addr_i != 5'd0) m_rf[bus.rd_addr_i] = bus.rd_data_i;
      else if (rdy && bus.dbg_addr_i != 5'd0)   m_rf[bus.dbg_addr_i] = bus.dbg_data_i;
      m_rv = bus.dbg_ren_i;
      if (bus.dbg_ren_i) m_dbg = snap;
      #1;
      chk("dbg_rvalid", {31'd0, bus.dbg_rvalid_o}, {31'd0, m_rv});
      chk("dbg_data", bus.dbg_data_o, m_dbg);
   endtask

   function automatic vec_t mk(input logic wen, input logic [4:0] rd, input logic [31:0] rdd,
                               input logic [4:0] r1, input logic [4:0] r2,
                               input logic dwen, input logic dren, input logic [4:0] da,
                               input logic [31:0] dd, input logic [31:0] e1, input logic [31:0] e2,
                               input logic erdy, input logic erv, input logic [31:0] edbg);
      vec_t v;
      v.wen = wen; v.rd = rd; v.rdd = rdd; v.r1 = r1; v.r2 = r2;
      v.dwen = dwen; v.dren = dren; v.da = da; v.dd = dd;
      v.e1 = e1; v.e2 = e2; v.erdy = erdy; v.erv = erv; v.edbg = edbg;
      return v;
   endfunction

   initial begin
      // bypass / x0
      tv[0]  = mk(1'b1, 5'd7,  32'h12345678, 5'd7,  5'd7,  1'b0, 1'b0, 5'd0, 32'h0,        32'h12345678, 32'h12345678, 1'b0, 1'b0, 32'h0);
      tv[1]  = mk(1'b0, 5'd0,  32'h0,        5'd7,  5'd0,  1'b0, 1'b0, 5'd0, 32'h0,        32'h12345678, 32'h0,        1'b0, 1'b0, 32'h0);
      tv[2]  = mk(1'b1, 5'd0,  32'h12345678, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0, 32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 32'h0);
      tv[3]  = mk(1'b0, 5'd0,  32'h0,        5'd0,  5'd7,  1'b0, 1'b0, 5'd0, 32'h0,        32'h0,        32'h12345678, 1'b0, 1'b0, 32'h0);
      // debug read alongside execute write to the same register
      tv[4]  = mk(1'b1, 5'd9,  32'h42,       5'd9,  5'd9,  1'b0, 1'b1, 5'd9, 32'h0,        32'h42,       32'h42,       1'b0, 1'b1, 32'h42);
      tv[5]  = mk(1'b0, 5'd0,  32'h0,        5'd9,  5'd0,  1'b0, 1'b0, 5'd0, 32'h0,        32'h42,       32'h0,        1'b0, 1'b0, 32'h42);
      // debug read/write collision on x4
      tv[6]  = mk(1'b1, 5'd4,  32'h11111111, 5'd4,  5'd0,  1'b0, 1'b0, 5'd0, 32'h0,        32'h11111111, 32'h0,        1'b0, 1'b0, 32'h42);
      tv[7]  = mk(1'b0, 5'd0,  32'h0,        5'd4,  5'd0,  1'b1, 1'b1, 5'd4, 32'h22222222, 32'h11111111, 32'h0,        1'b1, 1'b1, 32'h11111111);
      tv[8]  = mk(1'b0, 5'd0,  32'h0,        5'd4,  5'd0,  1'b0, 1'b1, 5'd4, 32'h0,        32'h22222222, 32'h0,        1'b0, 1'b1, 32'h22222222);
      // debug write held off by three execute writes
      tv[9]  = mk(1'b1, 5'd10, 32'h5,        5'd3,  5'd0,  1'b1, 1'b0, 5'd3, 32'hCAFEF00D, 32'h0,        32'h0,        1'b0, 1'b0, 32'h22222222);
      tv[10] = mk(1'b1, 5'd11, 32'h6,        5'd10, 5'd0,  1'b1, 1'b0, 5'd3, 32'hCAFEF00D, 32'h5,        32'h0,        1'b0, 1'b0, 32'h22222222);
      tv[11] = mk(1'b1, 5'd12, 32'h7,        5'd11, 5'd0,  1'b1, 1'b0, 5'd3, 32'hCAFEF00D, 32'h6,        32'h0,        1'b0, 1'b0, 32'h22222222);
      tv[12] = mk(1'b0, 5'd0,  32'h0,        5'd3,  5'd12, 1'b1, 1'b0, 5'd3, 32'hCAFEF00D, 32'h0,        32'h7,        1'b1, 1'b0, 32'h22222222);
      tv[13] = mk(1'b0, 5'd0,  32'h0,        5'd3,  5'd0,  1'b0, 1'b0, 5'd0, 32'h0,        32'hCAFEF00D, 32'h0,        1'b0, 1'b0, 32'h22222222);
      // debug write/read of x0
      tv[14] = mk(1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 32'h0,        32'h0,        1'b1, 1'b1, 32'h0);
      tv[15] = mk(1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  1'b0, 1'b1, 5'd0, 32'h0,        32'h0,        32'h0,        1'b0, 1'b1, 32'h0);

      // ---- reset state
      rst = 1'b1;
      drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0);
      m_reset();
      #12;
      chk("rst_rvalid", {31'd0, bus.dbg_rvalid_o}, 32'd0);
      chk("rst_dbg_data", bus.dbg_data_o, 32'd0);
      chk("rst_rs1", bus.rs1_data_o, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // ---- table vectors
      for (int i = 0; i < 16; i++) begin
         drive(tv[i].wen, tv[i].rd, tv[i].rdd, tv[i].r1, tv[i].r2,
               tv[i].dwen, tv[i].dren, tv[i].da, tv[i].dd);
         tick();
         chk($sformatf("tv%0d_rs1", i), s_rs1, tv[i].e1);
         chk($sformatf("tv%0d_rs2", i), s_rs2, tv[i].e2);
         chk($sformatf("tv%0d_rdy", i), {31'd0, s_rdy}, {31'd0, tv[i].erdy});
         chk($sformatf("tv%0d_rv", i), {31'd0, bus.dbg_rvalid_o}, {31'd0, tv[i].erv});
         chk($sformatf("tv%0d_dbg", i), bus.dbg_data_o, tv[i].edbg);
      end

      // ---- reset asserted mid-cycle during a write
      drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 1'b0, 1'b1, 5'd5, 32'h0);
      tick();
      drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd6, 1'b0, 1'b0, 5'd0, 32'h0);
      #1;
      chk("pre_rst_x5", bus.rs1_data_o, 32'hDEADBEEF);
      chk("pre_rst_rvalid", {31'd0, bus.dbg_rvalid_o}, 32'd1);
      bus.reg_wen_i = 1'b1; bus.rd_addr_i = 5'd6; bus.rd_data_i = 32'h77777777;
      #1 rst = 1'b1;
      #1;
      chk("rst_x5", bus.rs1_data_o, 32'd0);
      chk("rst_bypass_x6", bus.rs2_data_o, 32'h77777777);
      chk("rst_mid_rvalid", {31'd0, bus.dbg_rvalid_o}, 32'd0);
      chk("rst_mid_dbg", bus.dbg_data_o, 32'd0);
      @(posedge clk); #1;
      bus.reg_wen_i = 1'b0;
      rst = 1'b0;
      m_reset();
      #1;
      chk("post_rst_x5", bus.rs1_data_o, 32'd0);
      chk("post_rst_x6", bus.rs2_data_o, 32'd0);

      // ---- sweep x1..x31
      for (int i = 1; i < 32; i++) begin
         drive(1'b1, 5'(i), 32'hA5A50000 + 32'(i), 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0);
         tick();
      end
      for (int i = 0; i < 32; i++) begin
         drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(i), 1'b0, 1'b0, 5'd0, 32'h0);
         tick();
         chk($sformatf("sweep_rs1_x%0d", i), s_rs1, (i == 0) ? 32'd0 : 32'hA5A50000 + 32'(i));
         chk($sformatf("sweep_rs2_x%0d", i), s_rs2, (i == 0) ? 32'd0 : 32'hA5A50000 + 32'(i));
      end

      // ---- random traffic against the model; small address pool half the time
      for (int n = 0; n < 600; n++) begin
         logic [4:0] ra, a1, a2, da;
         logic sm;
         sm = 1'($urandom_range(0, 1));
         ra = sm ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
         a1 = sm ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
         a2 = sm ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
         da = sm ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
         drive(1'($urandom_range(0, 1)), ra, $urandom, a1, a2,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), da, $urandom);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
